// File: rtl/vc_test_pkg.sv
// vc_test_pkg: shared types and constants for the val/rdy test sink.
// Provides the sink state encoding, the LFSR tap mask and default seed,
// and helpers that step the LFSR and derive a stall length from it.
package vc_test_pkg;

    typedef enum logic [1:0] {IDLE, DELAY, RECV, DONE} state_t;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] lfsr_delay(input logic [15:0] s, input logic [7:0] m);
        return s[7:0] & m;
    endfunction

endpackage

// File: rtl/vc_lfsr16.sv
// vc_lfsr16: 16-bit Fibonacci LFSR that steps only when enabled.
// Ports: clk, reset (async active-low, loads p_seed), en (advance one step),
//        state (current 16-bit LFSR value).
module vc_lfsr16 import vc_test_pkg::*; #(
    parameter logic [15:0] p_seed = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            state <= p_seed;
        else if (en)
            state <= lfsr_next(state);

endmodule

// File: rtl/vc_test_rand_delay_sink.sv
// vc_test_rand_delay_sink: val/rdy sink that checks messages against a preloaded
// expected/mask list and inserts pseudo-random stalls between messages.
// Ports: clk, reset (async active-low); msg_val/msg_rdy/msg (stream in);
//        load_en/load_addr/load_data/load_mask (expected-list write port);
//        go/num_msgs (start a run of num_msgs messages);
//        done, num_failed (saturating), fail (mismatch pulse), index (accepted count).
module vc_test_rand_delay_sink import vc_test_pkg::*; #(
    parameter int          p_msg_nbits = 32,
    parameter int          p_num_msgs  = 1024,
    parameter int          p_max_delay = 0,
    parameter logic [15:0] p_seed      = DEFAULT_SEED,
    localparam int         AW          = $clog2(p_num_msgs)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   msg_val,
    output logic                   msg_rdy,
    input  logic [p_msg_nbits-1:0] msg,
    input  logic                   load_en,
    input  logic [AW-1:0]          load_addr,
    input  logic [p_msg_nbits-1:0] load_data,
    input  logic [p_msg_nbits-1:0] load_mask,
    input  logic                   go,
    input  logic [AW:0]            num_msgs,
    output logic                   done,
    output logic [15:0]            num_failed,
    output logic                   fail,
    output logic [AW:0]            index
);

    state_t                 state;
    logic [p_msg_nbits-1:0] exp_mem  [p_num_msgs];
    logic [p_msg_nbits-1:0] mask_mem [p_num_msgs];
    logic [AW:0]            n;
    logic [7:0]             cnt;
    logic [15:0]            lfsr;
    logic                   hs;
    logic                   mismatch;
    logic [7:0]             delay_now;
    logic [7:0]             delay_hs;

    assign msg_rdy  = state == RECV;
    assign done     = state == DONE;
    assign hs       = msg_rdy && msg_val;
    assign mismatch = |((msg ^ exp_mem[index[AW-1:0]]) & mask_mem[index[AW-1:0]]);
    // A run's first stall uses the current LFSR value; a stall after a
    // handshake uses the value the LFSR steps to on that same edge, so
    // every gap draws a fresh value.
    assign delay_now = lfsr_delay(lfsr, 8'(p_max_delay));
    assign delay_hs  = lfsr_delay(lfsr_next(lfsr), 8'(p_max_delay));

    vc_lfsr16 #(.p_seed(p_seed)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (hs),
        .state (lfsr)
    );

    // Expected list is deliberately not reset so it survives a mid-run abort.
    always_ff @(posedge clk)
        if (load_en && (state == IDLE || state == DONE)) begin
            exp_mem[load_addr]  <= load_data;
            mask_mem[load_addr] <= load_mask;
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            n          <= '0;
            index      <= '0;
            num_failed <= '0;
            fail       <= 1'b0;
            cnt        <= '0;
        end else begin
            fail <= 1'b0;
            case (state)
                IDLE, DONE:
                    if (go) begin
                        n          <= num_msgs;
                        index      <= '0;
                        num_failed <= '0;
                        cnt        <= delay_now;
                        state      <= num_msgs == '0 ? DONE : delay_now == '0 ? RECV : DELAY;
                    end
                DELAY: begin
                    cnt <= cnt - 8'd1;
                    if (cnt == 8'd1)
                        state <= RECV;
                end
                RECV:
                    if (msg_val) begin
                        index <= index + 1'b1;
                        if (mismatch) begin
                            num_failed <= num_failed + 16'(num_failed != 16'hFFFF);
                            fail       <= 1'b1;
                        end
                        cnt   <= delay_hs;
                        state <= index + 1'b1 == n ? DONE : delay_hs == '0 ? RECV : DELAY;
                    end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_vc_test_rand_delay_sink.sv
// tb_vc_test_rand_delay_sink: self-checking bench for the random-delay test sink.
// Instance a has no stalls (back-to-back), instance b stalls by up to 7 cycles.
module tb_vc_test_rand_delay_sink;

    localparam int NUM = 32;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0, load_mask = '0;

    logic        go_a = 1'b0, val_a = 1'b0, rdy_a, done_a, fail_a;
    logic [31:0] msg_a = '0;
    logic [5:0]  n_a = '0, idx_a;
    logic [15:0] nf_a;

    logic        go_b = 1'b0, val_b = 1'b0, rdy_b, done_b, fail_b;
    logic [31:0] msg_b = '0;
    logic [5:0]  n_b = '0, idx_b;
    logic [15:0] nf_b;

    int checks = 0, errors = 0, nf_model = 0;

    typedef struct {
        logic [31:0] e;
        logic [31:0] m;
        logic [31:0] v;
        logic        f;
    } vec_t;
    vec_t tbl[8];

    logic [31:0] ex[NUM], mk[NUM], ms[NUM];
    logic        fe[NUM];

    always #5 clk = ~clk;

    vc_test_rand_delay_sink #(.p_msg_nbits(32), .p_num_msgs(NUM), .p_max_delay(0), .p_seed(SEED)) dut_a (
        .clk(clk), .reset(reset), .msg_val(val_a), .msg_rdy(rdy_a), .msg(msg_a),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_mask(load_mask),
        .go(go_a), .num_msgs(n_a), .done(done_a), .num_failed(nf_a), .fail(fail_a), .index(idx_a)
    );

    vc_test_rand_delay_sink #(.p_msg_nbits(32), .p_num_msgs(NUM), .p_max_delay(7), .p_seed(SEED)) dut_b (
        .clk(clk), .reset(reset), .msg_val(val_b), .msg_rdy(rdy_b), .msg(msg_b),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .load_mask(load_mask),
        .go(go_b), .num_msgs(n_b), .done(done_b), .num_failed(nf_b), .fail(fail_b), .index(idx_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_mismatch(input int i);
        return |((ms[i] ^ ex[i]) & mk[i]);
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic load(input int n);
        for (int i = 0; i < n; i++) begin
            load_en   = 1'b1;
            load_addr = 5'(i);
            load_data = ex[i];
            load_mask = mk[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic start_a(input int n);
        n_a      = 6'(n);
        go_a     = 1'b1;
        nf_model = 0;
        tick();
        go_a = 1'b0;
        chk("start_idx", 32'(idx_a), 0);
        chk("start_nfail", 32'(nf_a), 0);
        if (n != 0) chk("start_done_low", 32'(done_a), 0);
    endtask

    task automatic feed_a(input int first, input int last, input int n);
        val_a = 1'b1;
        for (int i = first; i <= last; i++) begin
            msg_a = ms[i];
            chk("a_rdy", 32'(rdy_a), 1);
            tick();
            if (fe[i]) nf_model++;
            chk("a_fail", 32'(fail_a), 32'(fe[i]));
            chk("a_index", 32'(idx_a), 32'(i + 1));
            chk("a_nfail", 32'(nf_a), 32'(nf_model));
            chk("a_done", 32'(done_a), 32'(i == n - 1));
        end
        val_a = 1'b0;
    endtask

    task automatic run_a(input int n);
        load(n);
        start_a(n);
        feed_a(0, n - 1, n);
        tick();
        chk("a_fail_clear", 32'(fail_a), 0);
        chk("a_done_hold", 32'(done_a), 1);
        chk("a_rdy_done", 32'(rdy_a), 0);
    endtask

    task automatic run_b(input int n);
        logic [15:0] ml;
        int d, gap, nf;
        for (int i = 0; i < n; i++) begin
            ex[i] = $urandom;
            mk[i] = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF_FFFF;
            ms[i] = ($urandom_range(0, 3) == 0) ? ex[i] ^ (32'h1 << $urandom_range(0, 31)) : ex[i];
        end
        load(n);
        ml   = SEED;
        d    = int'(ml[2:0]);
        nf   = 0;
        n_b  = 6'(n);
        go_b = 1'b1;
        tick();
        go_b  = 1'b0;
        val_b = 1'b1;
        for (int i = 0; i < n; i++) begin
            msg_b = ms[i];
            gap   = 0;
            while (!rdy_b && gap < 300) begin
                gap++;
                tick();
            end
            chk("b_gap", 32'(gap), 32'(d));
            tick();
            ml = model_step(ml);
            d  = int'(ml[2:0]);
            if (model_mismatch(i)) nf++;
            chk("b_fail", 32'(fail_b), 32'(model_mismatch(i)));
            chk("b_index", 32'(idx_b), 32'(i + 1));
            chk("b_nfail", 32'(nf_b), 32'(nf));
        end
        val_b = 1'b0;
        chk("b_done", 32'(done_b), 1);
        chk("b_rdy_done", 32'(rdy_b), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", 32'(rdy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_fail", 32'(fail_a), 0);
        chk("rst_nfail", 32'(nf_a), 0);
        chk("rst_index", 32'(idx_a), 0);
        reset = 1'b1;
        tick();

        // random stalls against a reference LFSR, fresh from reset
        run_b(20);

        // table of single-message behaviours applied as one back-to-back run
        tbl[0] = '{32'h1234_5678, 32'h0000_00FF, 32'hFFFF_FF78, 1'b0};
        tbl[1] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0};
        tbl[2] = '{32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'hDEAD_BEEE, 1'b1};
        tbl[3] = '{32'hA5A5_A5A5, 32'hF0F0_F0F0, 32'hA0A0_A0A0, 1'b0};
        tbl[4] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1};
        tbl[5] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[6] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        tbl[7] = '{32'h0F0F_0000, 32'h0000_FFFF, 32'h0F0F_1000, 1'b1};
        for (int i = 0; i < 8; i++) begin
            ex[i] = tbl[i].e;
            mk[i] = tbl[i].m;
            ms[i] = tbl[i].v;
            fe[i] = tbl[i].f;
        end
        run_a(8);

        // three matching messages back-to-back
        for (int i = 0; i < 3; i++) begin
            ex[i] = 32'(i + 1);
            mk[i] = 32'hFFFF_FFFF;
            ms[i] = 32'(i + 1);
            fe[i] = model_mismatch(i);
        end
        run_a(3);

        // second message wrong
        ms[1] = 32'd7;
        fe[1] = model_mismatch(1);
        run_a(3);

        // zero-length run
        start_a(0);
        chk("n0_done", 32'(done_a), 1);
        for (int i = 0; i < 3; i++) begin
            chk("n0_rdy", 32'(rdy_a), 0);
            tick();
        end

        // load during RECV must be ignored
        for (int i = 0; i < 3; i++) begin
            ex[i] = 32'(i + 5);
            mk[i] = 32'hFFFF_FFFF;
            ms[i] = 32'(i + 5);
            fe[i] = 1'b0;
        end
        load(3);
        start_a(3);
        load_en   = 1'b1;
        load_addr = 5'd1;
        load_data = 32'd99;
        load_mask = 32'hFFFF_FFFF;
        tick();
        load_en = 1'b0;
        feed_a(0, 2, 3);

        // abort mid-run with reset, then rerun from retained memory
        for (int i = 0; i < 4; i++) begin
            ex[i] = 32'(10 * (i + 1));
            mk[i] = 32'hFFFF_FFFF;
            ms[i] = ex[i];
            fe[i] = 1'b0;
        end
        load(4);
        start_a(4);
        feed_a(0, 1, 4);
        chk("mid_index", 32'(idx_a), 2);
        chk("mid_rdy", 32'(rdy_a), 1);
        #2 reset = 1'b0;
        #1;
        chk("abort_rdy", 32'(rdy_a), 0);
        chk("abort_index", 32'(idx_a), 0);
        chk("abort_done", 32'(done_a), 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_rdy", 32'(rdy_a), 0);
        chk("post_rst_done", 32'(done_a), 0);
        start_a(4);
        feed_a(0, 3, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
